// File: rtl/csel_adder_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder.
package csel_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 2;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// Valid/ready operand and result bus of the pipelined carry-select adder.
// The overflow signal exists only when CSEL_OVERFLOW_EN is defined.
interface pipelined_csel_adder_if
  import csel_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSEL_OVERFLOW_EN
  logic             overflow;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/csel_block.sv
// One carry-select block: both carry-in cases are summed in parallel and the
// real block carry picks the result.
module csel_block
  import csel_adder_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0] res_c0;
  logic [BLOCK:0] res_c1;

  assign res_c0 = {1'b0, a} + {1'b0, b};
  assign res_c1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign {cout, sum} = cin ? res_c1 : res_c0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder: each stage adds one WIDTH/STAGES-bit slice and
// the whole pipe advances together. Signed overflow output under CSEL_OVERFLOW_EN.
module pipelined_csel_adder
  import csel_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_csel_adder_if.slave bus
);

  localparam int SW = slice_width(WIDTH, STAGES);
  localparam int NB = SW / BLOCK;

  if ((WIDTH % (STAGES * BLOCK)) != 0) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a multiple of STAGES*BLOCK");
  end

  logic adv;
  logic out_valid;

  // The pipe only stalls when a finished result is being refused downstream.
  assign adv          = bus.out_ready | ~out_valid;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic             v_i;
    logic             c_i;
    logic [WIDTH-1:LO] a_i;
    logic [WIDTH-1:LO] b_i;
    logic [SW-1:0]    slice_sum;
    logic             slice_co;
    logic [HI-1:0]    sum_new;

    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic [HI-1:0]    sum_q, sum_d;

    if (k == 0) begin : g_src
      assign v_i     = bus.in_valid;
      assign c_i     = bus.cin;
      assign a_i     = bus.a;
      assign b_i     = bus.b;
      assign sum_new = slice_sum;
    end else begin : g_src
      assign v_i     = g_stage[k-1].valid_q;
      assign c_i     = g_stage[k-1].carry_q;
      assign a_i     = g_stage[k-1].g_fwd.a_q;
      assign b_i     = g_stage[k-1].g_fwd.b_q;
      assign sum_new = {slice_sum, g_stage[k-1].sum_q};
    end

    for (genvar j = 0; j < NB; j++) begin : g_blk
      logic ci;
      logic co;

      if (j == 0) begin : g_ci
        assign ci = c_i;
      end else begin : g_ci
        assign ci = g_blk[j-1].co;
      end

      csel_block #(.BLOCK(BLOCK)) u_blk (
        .a    (a_i[LO + j*BLOCK +: BLOCK]),
        .b    (b_i[LO + j*BLOCK +: BLOCK]),
        .cin  (ci),
        .sum  (slice_sum[j*BLOCK +: BLOCK]),
        .cout (co)
      );
    end

    assign slice_co = g_blk[NB-1].co;

    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      if (adv) begin
        valid_d = v_i;
        carry_d = slice_co;
        sum_d   = sum_new;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Operand bits still waiting for a later slice.
      logic [WIDTH-1:HI] a_q, a_d;
      logic [WIDTH-1:HI] b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_i[WIDTH-1:HI];
          b_d = b_i[WIDTH-1:HI];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_out
      assign out_valid = valid_q;
      assign bus.sum   = sum_q;
      assign bus.cout  = carry_q;

`ifdef CSEL_OVERFLOW_EN
      logic ovf_q, ovf_d;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
          ovf_d = a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ slice_sum[SW-1] ^ slice_co;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign bus.overflow = ovf_q;
`endif
    end
  end

endmodule
